// File: rtl/complex_int_register_read_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | complex_int_register_read_stage                                            |
// | Register-read stage of the complex-integer pipe: operand fetch, bypass,    |
// | stall-time result capture and selective flush ahead of complex execute.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module complex_int_register_read_stage #(
   parameter int WIDTH    = 1,
   parameter int AL_PTR_W = 6,
   parameter int PREG_W   = 7,
   parameter int DATA_W   = 32,
   parameter int OP_W     = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         stall,
   input  logic                         clear,
   input  logic [WIDTH-1:0]             in_valid,
   input  logic [WIDTH-1:0]             in_replay,
   input  logic [WIDTH*AL_PTR_W-1:0]    in_al_ptr,
   input  logic [WIDTH*OP_W-1:0]        in_op,
   input  logic [WIDTH*PREG_W-1:0]      in_dst,
   input  logic [WIDTH*PREG_W-1:0]      in_src_a,
   input  logic [WIDTH*PREG_W-1:0]      in_src_b,
   input  logic [WIDTH-1:0]             in_src_a_en,
   input  logic [WIDTH-1:0]             in_src_b_en,
   input  logic                         to_recovery,
   input  logic [AL_PTR_W-1:0]          flush_head,
   input  logic [AL_PTR_W-1:0]          flush_tail,
   input  logic                         flush_all,
   output logic [WIDTH*PREG_W-1:0]      rf_addr_a,
   output logic [WIDTH*PREG_W-1:0]      rf_addr_b,
   input  logic [WIDTH*DATA_W-1:0]      rf_data_a,
   input  logic [WIDTH*DATA_W-1:0]      rf_data_b,
   input  logic                         wb_valid,
   input  logic [PREG_W-1:0]            wb_dst,
   input  logic [DATA_W-1:0]            wb_data,
   output logic [WIDTH-1:0]             out_valid,
   output logic [WIDTH-1:0]             out_replay,
   output logic [WIDTH*AL_PTR_W-1:0]    out_al_ptr,
   output logic [WIDTH*OP_W-1:0]        out_op,
   output logic [WIDTH*PREG_W-1:0]      out_dst,
   output logic [WIDTH*DATA_W-1:0]      out_opnd_a,
   output logic [WIDTH*DATA_W-1:0]      out_opnd_b
);

   // Flush range is [head, tail) on a circular pointer; head==tail is empty.
   function automatic logic flush_hit(
      input logic                rec,
      input logic                all,
      input logic [AL_PTR_W-1:0] head,
      input logic [AL_PTR_W-1:0] tail,
      input logic [AL_PTR_W-1:0] p
   );
      logic in_range;
      if (head <= tail)
         in_range = (p >= head) && (p < tail);
      else
         in_range = (p >= head) || (p < tail);
      return rec && (all || in_range);
   endfunction

   genvar g;
   generate
      for (g = 0; g < WIDTH; g++) begin : g_lane
         logic                r_valid;
         logic                r_replay;
         logic [AL_PTR_W-1:0] r_al_ptr;
         logic [OP_W-1:0]     r_op;
         logic [PREG_W-1:0]   r_dst;
         logic [PREG_W-1:0]   r_src_a;
         logic [PREG_W-1:0]   r_src_b;
         logic                r_src_a_en;
         logic                r_src_b_en;
         logic                r_cap_a;
         logic                r_cap_b;
         logic [DATA_W-1:0]   r_hold_a;
         logic [DATA_W-1:0]   r_hold_b;
         logic                w_flush;
         logic                w_hit_a;
         logic                w_hit_b;
         logic [DATA_W-1:0]   w_opnd_a;
         logic [DATA_W-1:0]   w_opnd_b;

         assign w_flush = flush_hit(to_recovery, flush_all, flush_head, flush_tail, r_al_ptr);
         assign w_hit_a = wb_valid && (wb_dst == r_src_a);
         assign w_hit_b = wb_valid && (wb_dst == r_src_b);

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_valid    <= 1'b0;
               r_replay   <= 1'b0;
               r_al_ptr   <= '0;
               r_op       <= '0;
               r_dst      <= '0;
               r_src_a    <= '0;
               r_src_b    <= '0;
               r_src_a_en <= 1'b0;
               r_src_b_en <= 1'b0;
               r_cap_a    <= 1'b0;
               r_cap_b    <= 1'b0;
               r_hold_a   <= '0;
               r_hold_b   <= '0;
            end else if (!stall) begin
               r_valid    <= in_valid[g];
               r_replay   <= in_replay[g];
               r_al_ptr   <= in_al_ptr[g*AL_PTR_W +: AL_PTR_W];
               r_op       <= in_op[g*OP_W +: OP_W];
               r_dst      <= in_dst[g*PREG_W +: PREG_W];
               r_src_a    <= in_src_a[g*PREG_W +: PREG_W];
               r_src_b    <= in_src_b[g*PREG_W +: PREG_W];
               r_src_a_en <= in_src_a_en[g];
               r_src_b_en <= in_src_b_en[g];
               r_cap_a    <= 1'b0;
               r_cap_b    <= 1'b0;
            end else begin
               // First matching writeback wins; later ones to the same preg are ignored.
               r_valid <= r_valid && !w_flush;
               if (w_hit_a && r_src_a_en && !r_cap_a) begin
                  r_hold_a <= wb_data;
                  r_cap_a  <= 1'b1;
               end
               if (w_hit_b && r_src_b_en && !r_cap_b) begin
                  r_hold_b <= wb_data;
                  r_cap_b  <= 1'b1;
               end
            end
         end

         always_comb begin
            w_opnd_a = rf_data_a[g*DATA_W +: DATA_W];
            if (!r_src_a_en)  w_opnd_a = '0;
            else if (r_cap_a) w_opnd_a = r_hold_a;
            else if (w_hit_a) w_opnd_a = wb_data;
         end

         always_comb begin
            w_opnd_b = rf_data_b[g*DATA_W +: DATA_W];
            if (!r_src_b_en)  w_opnd_b = '0;
            else if (r_cap_b) w_opnd_b = r_hold_b;
            else if (w_hit_b) w_opnd_b = wb_data;
         end

         assign rf_addr_a[g*PREG_W +: PREG_W]     = r_src_a;
         assign rf_addr_b[g*PREG_W +: PREG_W]     = r_src_b;
         assign out_valid[g]                      = r_valid && !stall && !clear && !w_flush;
         assign out_replay[g]                     = r_replay;
         assign out_al_ptr[g*AL_PTR_W +: AL_PTR_W] = r_al_ptr;
         assign out_op[g*OP_W +: OP_W]            = r_op;
         assign out_dst[g*PREG_W +: PREG_W]       = r_dst;
         assign out_opnd_a[g*DATA_W +: DATA_W]    = w_opnd_a;
         assign out_opnd_b[g*DATA_W +: DATA_W]    = w_opnd_b;
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_complex_int_register_read_stage.sv
`timescale 1ns/1ps
`default_nettype none
// Randomized and directed bench for complex_int_register_read_stage (single lane)
// checked against a transaction-level model of the held op.
module tb_complex_int_register_read_stage;
   localparam int WIDTH    = 1;
   localparam int AL_PTR_W = 6;
   localparam int PREG_W   = 7;
   localparam int DATA_W   = 32;
   localparam int OP_W     = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic                      stall, clear;
   logic [WIDTH-1:0]          in_valid, in_replay, in_src_a_en, in_src_b_en;
   logic [WIDTH*AL_PTR_W-1:0] in_al_ptr;
   logic [WIDTH*OP_W-1:0]     in_op;
   logic [WIDTH*PREG_W-1:0]   in_dst, in_src_a, in_src_b;
   logic                      to_recovery, flush_all;
   logic [AL_PTR_W-1:0]       flush_head, flush_tail;
   logic [WIDTH*PREG_W-1:0]   rf_addr_a, rf_addr_b;
   logic [WIDTH*DATA_W-1:0]   rf_data_a, rf_data_b;
   logic                      wb_valid;
   logic [PREG_W-1:0]         wb_dst;
   logic [DATA_W-1:0]         wb_data;
   logic [WIDTH-1:0]          out_valid, out_replay;
   logic [WIDTH*AL_PTR_W-1:0] out_al_ptr;
   logic [WIDTH*OP_W-1:0]     out_op;
   logic [WIDTH*PREG_W-1:0]   out_dst;
   logic [WIDTH*DATA_W-1:0]   out_opnd_a, out_opnd_b;

   logic [DATA_W-1:0] rf_mem [2**PREG_W];
   always_comb rf_data_a = rf_mem[rf_addr_a];
   always_comb rf_data_b = rf_mem[rf_addr_b];

   complex_int_register_read_stage #(
      .WIDTH(WIDTH), .AL_PTR_W(AL_PTR_W), .PREG_W(PREG_W), .DATA_W(DATA_W), .OP_W(OP_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .clear(clear),
      .in_valid(in_valid), .in_replay(in_replay), .in_al_ptr(in_al_ptr), .in_op(in_op),
      .in_dst(in_dst), .in_src_a(in_src_a), .in_src_b(in_src_b),
      .in_src_a_en(in_src_a_en), .in_src_b_en(in_src_b_en),
      .to_recovery(to_recovery), .flush_head(flush_head), .flush_tail(flush_tail),
      .flush_all(flush_all), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
      .rf_data_a(rf_data_a), .rf_data_b(rf_data_b), .wb_valid(wb_valid),
      .wb_dst(wb_dst), .wb_data(wb_data), .out_valid(out_valid), .out_replay(out_replay),
      .out_al_ptr(out_al_ptr), .out_op(out_op), .out_dst(out_dst),
      .out_opnd_a(out_opnd_a), .out_opnd_b(out_opnd_b)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: the op currently held by the stage, plus captured values.
   bit                  m_valid, m_replay, m_sae, m_sbe, m_cap_a, m_cap_b;
   logic [AL_PTR_W-1:0] m_al;
   logic [OP_W-1:0]     m_op;
   logic [PREG_W-1:0]   m_dst, m_sa, m_sb;
   logic [DATA_W-1:0]   m_hold_a, m_hold_b;

   task automatic model_reset();
      m_valid = 0; m_replay = 0; m_sae = 0; m_sbe = 0; m_cap_a = 0; m_cap_b = 0;
      m_al = '0; m_op = '0; m_dst = '0; m_sa = '0; m_sb = '0; m_hold_a = '0; m_hold_b = '0;
   endtask

   // Circular-distance form of the flush window: p is inside when its offset from
   // head is below the window length (tail - head) modulo the pointer space.
   function automatic bit killed(input logic [AL_PTR_W-1:0] p);
      logic [AL_PTR_W-1:0] off, len;
      off = p - flush_head;
      len = flush_tail - flush_head;
      return to_recovery && (flush_all || (off < len));
   endfunction

   function automatic logic [DATA_W-1:0] exp_opnd(input bit en, input bit cap,
      input logic [DATA_W-1:0] hold, input logic [PREG_W-1:0] src);
      if (!en) return '0;
      if (cap) return hold;
      if (wb_valid && wb_dst == src) return wb_data;
      return rf_mem[src];
   endfunction

   task automatic model_edge();
      if (!stall) begin
         m_valid = in_valid[0]; m_replay = in_replay[0]; m_al = in_al_ptr; m_op = in_op;
         m_dst = in_dst; m_sa = in_src_a; m_sb = in_src_b;
         m_sae = in_src_a_en[0]; m_sbe = in_src_b_en[0]; m_cap_a = 0; m_cap_b = 0;
      end else begin
         m_valid = m_valid && !killed(m_al);
         if (wb_valid && m_sae && wb_dst == m_sa && !m_cap_a) begin
            m_cap_a = 1; m_hold_a = wb_data;
         end
         if (wb_valid && m_sbe && wb_dst == m_sb && !m_cap_b) begin
            m_cap_b = 1; m_hold_b = wb_data;
         end
      end
   endtask

   task automatic check_outputs();
      chk("valid",   out_valid, 64'(m_valid && !stall && !clear && !killed(m_al)));
      chk("replay",  out_replay, 64'(m_replay));
      chk("al_ptr",  out_al_ptr, 64'(m_al));
      chk("op",      out_op, 64'(m_op));
      chk("dst",     out_dst, 64'(m_dst));
      chk("rf_addr_a", rf_addr_a, 64'(m_sa));
      chk("rf_addr_b", rf_addr_b, 64'(m_sb));
      chk("opnd_a",  out_opnd_a, 64'(exp_opnd(m_sae, m_cap_a, m_hold_a, m_sa)));
      chk("opnd_b",  out_opnd_b, 64'(exp_opnd(m_sbe, m_cap_b, m_hold_b, m_sb)));
   endtask

   task automatic idle();
      stall = 0; clear = 0; in_valid = '0; in_replay = '0; in_al_ptr = '0; in_op = '0;
      in_dst = '0; in_src_a = '0; in_src_b = '0; in_src_a_en = '0; in_src_b_en = '0;
      to_recovery = 0; flush_all = 0; flush_head = '0; flush_tail = '0;
      wb_valid = 0; wb_dst = '0; wb_data = '0;
   endtask

   // Called at a negedge with inputs set; checks, crosses the posedge, returns at next negedge.
   task automatic tick();
      #1 check_outputs();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
   endtask

   task automatic load(input logic [AL_PTR_W-1:0] al, input logic [PREG_W-1:0] sa,
                       input bit sae, input logic [PREG_W-1:0] sb, input bit sbe);
      idle();
      in_valid = 1'b1; in_al_ptr = al; in_op = 4'h3; in_dst = 7'h21;
      in_src_a = sa; in_src_a_en = sae; in_src_b = sb; in_src_b_en = sbe;
      tick();
   endtask

   task automatic test_basic_load();
      rf_mem[5] = 32'h11;
      load(6'd1, 7'd5, 1, 7'd0, 0);
      idle();
      #1 chk("t1_valid", out_valid, 1);
      chk("t1_opnd_a", out_opnd_a, 32'h11);
      tick();
   endtask

   initial begin
      idle();
      for (int i = 0; i < 2**PREG_W; i++) rf_mem[i] = $urandom;
      model_reset();
      repeat (2) @(negedge clk);
      #1 check_outputs();
      chk("reset_valid", out_valid, 0);
      @(negedge clk);
      rst_n = 1;

      test_basic_load();

      // Writeback bypass beats RF data
      rf_mem[9] = 32'h1234;
      load(6'd2, 7'd0, 0, 7'd9, 1);
      idle(); wb_valid = 1; wb_dst = 7'd9; wb_data = 32'hABCD;
      #1 chk("t2_opnd_b", out_opnd_b, 32'hABCD);
      tick();

      // Capture during stall
      rf_mem[9] = 32'h77;
      load(6'd3, 7'd9, 1, 7'd0, 0);
      idle(); stall = 1;
      #1 chk("t3_stall1_valid", out_valid, 0);
      tick();
      idle(); stall = 1; wb_valid = 1; wb_dst = 7'd9; wb_data = 32'h55;
      tick();
      idle(); stall = 1;
      tick();
      idle(); rf_mem[9] = 32'h0;
      #1 chk("t3_opnd_a", out_opnd_a, 32'h55);
      chk("t3_valid", out_valid, 1);
      tick();

      // Wrapped flush window [60, 2)
      for (int k = 0; k < 2; k++) begin
         load((k == 0) ? 6'd62 : 6'd10, 7'd1, 1, 7'd2, 1);
         idle(); stall = 1; to_recovery = 1; flush_head = 6'd60; flush_tail = 6'd2;
         tick();
         idle(); stall = 1;
         tick();
         idle();
         #1 chk((k == 0) ? "t4_wrap_killed" : "t4_wrap_survive", out_valid, (k == 0) ? 0 : 1);
         tick();
      end

      // Empty window only flushes with flush_all
      for (int k = 0; k < 2; k++) begin
         load(6'd7, 7'd3, 1, 7'd4, 0);
         idle(); stall = 1; to_recovery = 1; flush_all = (k == 0);
         flush_head = 6'd7; flush_tail = 6'd7;
         tick();
         idle();
         #1 chk((k == 0) ? "t5_flush_all" : "t5_empty_window", out_valid, (k == 0) ? 0 : 1);
         tick();
      end

      // Asynchronous reset while stalled with captured data
      load(6'd5, 7'd9, 1, 7'd0, 0);
      idle(); stall = 1; wb_valid = 1; wb_dst = 7'd9; wb_data = 32'h99;
      tick();
      idle(); stall = 1;
      #2 rst_n = 0;
      #1 model_reset();
      chk("t6_valid", out_valid, 0);
      chk("t6_opnd_a", out_opnd_a, 0);
      check_outputs();
      @(negedge clk);
      rst_n = 1; idle();
      test_basic_load();

      // Randomized traffic with a small preg range so bypass hits are frequent
      for (int c = 0; c < 400; c++) begin
         stall = ($urandom_range(0, 9) < 3);
         clear = ($urandom_range(0, 9) == 0);
         in_valid = 1'($urandom); in_replay = 1'($urandom);
         in_al_ptr = 6'($urandom); in_op = 4'($urandom); in_dst = 7'($urandom);
         in_src_a = 7'($urandom_range(0, 7)); in_src_b = 7'($urandom_range(0, 7));
         in_src_a_en = 1'($urandom); in_src_b_en = 1'($urandom);
         to_recovery = ($urandom_range(0, 6) == 0); flush_all = ($urandom_range(0, 4) == 0);
         flush_head = 6'($urandom); flush_tail = 6'($urandom);
         wb_valid = 1'($urandom); wb_dst = 7'($urandom_range(0, 7)); wb_data = $urandom;
         rf_mem[$urandom_range(0, 7)] = $urandom;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
